// File: rtl/regdump_pkg.sv
// Shared types and constants for the register-file dump controller.
// REGDUMP_HEADER_EN adds the HDR frame-marker state.
package regdump_pkg;
  localparam int         BYTES_PER_WORD      = 4;
  localparam logic [7:0] DEFAULT_HEADER_BYTE = 8'hA5;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_ADDR = 3'd1,
    ST_LOAD = 3'd2,
    ST_SEND = 3'd3,
`ifdef REGDUMP_HEADER_EN
    ST_DONE = 3'd4,
    ST_HDR  = 3'd5
`else
    ST_DONE = 3'd4
`endif
  } state_t;
endpackage

// File: rtl/word_serializer.sv
// 32-bit MSB-first byte serializer with valid/ready handshake.
// Flags the edge on which the last byte of the word is accepted.
module word_serializer
  import regdump_pkg::*;
(
  input  logic        clk,
  input  logic        i_reset,
  input  logic        i_load,
  input  logic [31:0] i_word,
  input  logic        i_valid,
  input  logic        i_ready,
  output logic [7:0]  o_byte,
  output logic        o_last_acc
);
  localparam logic [1:0] LAST_CNT = 2'(BYTES_PER_WORD - 1);

  logic [31:0] r_shift;
  logic [1:0]  r_cnt;
  logic        w_xfer;

  assign w_xfer     = i_valid & i_ready;
  assign o_byte     = r_shift[31:24];
  assign o_last_acc = w_xfer & (r_cnt == LAST_CNT);

  always_ff @(posedge clk) begin
    if (i_reset) begin
      r_shift <= '0;
      r_cnt   <= '0;
    end else if (i_load) begin
      r_shift <= i_word;
      r_cnt   <= '0;
    end else if (w_xfer) begin
      r_shift <= {r_shift[23:0], 8'h00};
      r_cnt   <= r_cnt + 2'd1;
    end
  end
endmodule

// File: rtl/regfile_dump_ctrl.sv
// Dumps N_REGS register-file words to a UART byte stream, MSB first.
// Define REGDUMP_HEADER_EN to prefix the frame with HEADER_BYTE.
module regfile_dump_ctrl
  import regdump_pkg::*;
#(
  parameter int         N_REGS      = 32,
  parameter logic [7:0] HEADER_BYTE = DEFAULT_HEADER_BYTE
) (
  input  logic        clk,
  input  logic        i_reset,
  input  logic        i_start,
  input  logic        i_halted,
  output logic [4:0]  o_rf_addr,
  input  logic [31:0] i_rf_data,
  output logic [7:0]  o_tx_data,
  output logic        o_tx_valid,
  input  logic        i_tx_ready,
  output logic        o_busy,
  output logic        o_done
);
  localparam logic [4:0] LAST_IDX = 5'(N_REGS - 1);

  state_t      r_state, w_state_nxt;
  logic [4:0]  r_idx, w_idx_nxt;
  logic [4:0]  r_rf_addr;
  logic        w_load;
  logic        w_ser_valid;
  logic        w_last_acc;
  logic [7:0]  w_byte;

  assign w_ser_valid = (r_state == ST_SEND);

  word_serializer u_ser (
    .clk        (clk),
    .i_reset    (i_reset),
    .i_load     (w_load),
    .i_word     (i_rf_data),
    .i_valid    (w_ser_valid),
    .i_ready    (i_tx_ready),
    .o_byte     (w_byte),
    .o_last_acc (w_last_acc)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    w_load      = 1'b0;
    case (r_state)
      ST_IDLE: if (i_start && i_halted) begin
        w_idx_nxt = '0;
`ifdef REGDUMP_HEADER_EN
        w_state_nxt = ST_HDR;
`else
        w_state_nxt = ST_ADDR;
`endif
      end
`ifdef REGDUMP_HEADER_EN
      ST_HDR:  if (i_tx_ready) w_state_nxt = ST_ADDR;
`endif
      ST_ADDR: w_state_nxt = ST_LOAD;
      ST_LOAD: begin
        w_load      = 1'b1;
        w_state_nxt = ST_SEND;
      end
      ST_SEND: if (w_last_acc) begin
        if (r_idx == LAST_IDX) begin
          w_state_nxt = ST_DONE;
        end else begin
          w_idx_nxt   = r_idx + 5'd1;
          w_state_nxt = ST_ADDR;
        end
      end
      ST_DONE: w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Address is registered on entry to ADDR so the synchronous regfile
  // returns the word in LOAD.
  always_ff @(posedge clk) begin
    if (i_reset) begin
      r_state   <= ST_IDLE;
      r_idx     <= '0;
      r_rf_addr <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_idx   <= w_idx_nxt;
      if (w_state_nxt == ST_ADDR) r_rf_addr <= w_idx_nxt;
    end
  end

  assign o_rf_addr = r_rf_addr;
`ifdef REGDUMP_HEADER_EN
  assign o_tx_valid = (r_state == ST_SEND) || (r_state == ST_HDR);
`else
  assign o_tx_valid = (r_state == ST_SEND);
`endif
  // Header byte appears only when valid is raised outside SEND.
  assign o_tx_data  = (r_state == ST_SEND) ? w_byte : HEADER_BYTE;
  assign o_busy     = (r_state != ST_IDLE);
  assign o_done     = (r_state == ST_DONE);
endmodule

// File: tb/tb_regfile_dump_ctrl.sv
// Scoreboard bench for regfile_dump_ctrl: full dumps, backpressure, ignored
// starts, mid-frame reset, and a single-register instance.
module tb_regfile_dump_ctrl;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, start, halted, ready;
  logic [4:0]  addr;
  logic [31:0] rf_data;
  logic [7:0]  txd;
  logic        txv, busy, done;

  logic        rst1, start1, ready1;
  logic [4:0]  addr1;
  logic [31:0] rf1_data;
  logic [7:0]  txd1;
  logic        txv1, busy1, done1;

  regfile_dump_ctrl #(.N_REGS(32)) u_dut (
    .clk(clk), .i_reset(rst), .i_start(start), .i_halted(halted),
    .o_rf_addr(addr), .i_rf_data(rf_data), .o_tx_data(txd),
    .o_tx_valid(txv), .i_tx_ready(ready), .o_busy(busy), .o_done(done)
  );

  regfile_dump_ctrl #(.N_REGS(1)) u_dut1 (
    .clk(clk), .i_reset(rst1), .i_start(start1), .i_halted(1'b1),
    .o_rf_addr(addr1), .i_rf_data(rf1_data), .o_tx_data(txd1),
    .o_tx_valid(txv1), .i_tx_ready(ready1), .o_busy(busy1), .o_done(done1)
  );

  logic [31:0] regs [32];
  initial for (int k = 0; k < 32; k++) regs[k] = 32'h1000_0000 + k;
  always @(posedge clk) rf_data  <= regs[addr];
  always @(posedge clk) rf1_data <= (addr1 == 5'd0) ? 32'hDEADBEEF : 32'h0;

  int n_cmp = 0, n_err = 0;
  int n_bytes = 0, n_done = 0, n_done1 = 0;
  logic [7:0] sb [$];
  logic [7:0] sb1 [$];
  logic       held_v = 1'b0;
  logic [7:0] held_d = 8'h00;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Transfers happen on the next rising edge; sample on the falling edge.
  always @(negedge clk) begin
    if (!rst) begin
      if (held_v && txv) chk("hold_stable", {24'h0, txd}, {24'h0, held_d});
      if (txv && ready) begin
        chk("sb_has", 32'(sb.size() != 0), 32'd1);
        if (sb.size() != 0) chk("byte", {24'h0, txd}, {24'h0, sb.pop_front()});
        n_bytes++;
      end
      if (done) n_done++;
      held_v = txv && !ready;
      held_d = txd;
    end else begin
      held_v = 1'b0;
    end
    if (!rst1) begin
      if (txv1 && ready1) begin
        chk("sb1_has", 32'(sb1.size() != 0), 32'd1);
        if (sb1.size() != 0) chk("byte1", {24'h0, txd1}, {24'h0, sb1.pop_front()});
      end
      if (done1) n_done1++;
    end
  end

  task automatic push_frame();
`ifdef REGDUMP_HEADER_EN
    sb.push_back(8'hA5);
`endif
    for (int k = 0; k < 32; k++)
      for (int b = 3; b >= 0; b--) sb.push_back(8'(regs[k] >> (8 * b)));
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget, input bit bp, input string tag);
    int d0;
    int c;
    d0 = n_done;
    c  = 0;
    while (n_done == d0 && c < budget) begin
      @(posedge clk); #1;
      c++;
      if (bp) ready = (c % 3 == 0);
    end
    ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk({tag, "_done_once"}, 32'(n_done - d0), 32'd1);
    chk({tag, "_sb_empty"}, 32'(sb.size()), 32'd0);
    chk({tag, "_idle"}, {31'h0, busy}, 32'd0);
  endtask

  initial begin
    int nb0;
    int c;
    rst = 1'b1; start = 1'b0; halted = 1'b1; ready = 1'b1;
    rst1 = 1'b1; start1 = 1'b0; ready1 = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy",  {31'h0, busy}, 32'd0);
    chk("rst_valid", {31'h0, txv},  32'd0);
    chk("rst_done",  {31'h0, done}, 32'd0);
    chk("rst_addr",  {27'h0, addr}, 32'd0);
    rst = 1'b0; rst1 = 1'b0;
    @(posedge clk); #1;

    // Plain dump, transmitter always ready
    push_frame();
    pulse_start();
    wait_done(2000, 1'b0, "dump");
    chk("addr_hold", {27'h0, addr}, 32'd31);

    // Backpressure: ready one cycle in three
    push_frame();
    pulse_start();
    wait_done(4000, 1'b1, "dump_bp");

    // Start while not halted is ignored
    halted = 1'b0;
    start  = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk("nohalt_busy", {31'h0, busy}, 32'd0);
    end
    start  = 1'b0;
    halted = 1'b1;

    // Second start mid-dump ignored; halt drop does not abort
    push_frame();
    pulse_start();
    repeat (20) @(posedge clk);
    #1;
    pulse_start();
    halted = 1'b0;
    wait_done(2000, 1'b0, "restart_ign");
    repeat (20) @(posedge clk);
    #1;
    chk("one_frame_busy", {31'h0, busy}, 32'd0);
    halted = 1'b1;

    // Reset mid-frame, then a fresh dump from register 0
    push_frame();
    nb0 = n_bytes;
    pulse_start();
    c = 0;
    while (n_bytes - nb0 < 50 && c < 2000) begin
      @(posedge clk); #1;
      c++;
    end
    chk("reached_byte50", 32'(n_bytes - nb0 >= 50), 32'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("midrst_valid", {31'h0, txv},  32'd0);
    chk("midrst_busy",  {31'h0, busy}, 32'd0);
    chk("midrst_addr",  {27'h0, addr}, 32'd0);
    rst = 1'b0;
    sb.delete();
    repeat (5) @(posedge clk);
    #1;
    chk("post_rst_quiet", {31'h0, txv}, 32'd0);
    push_frame();
    pulse_start();
    wait_done(2000, 1'b0, "resend");

    // Single-register instance
`ifdef REGDUMP_HEADER_EN
    sb1.push_back(8'hA5);
`endif
    sb1.push_back(8'hDE); sb1.push_back(8'hAD);
    sb1.push_back(8'hBE); sb1.push_back(8'hEF);
    start1 = 1'b1;
    @(posedge clk); #1;
    start1 = 1'b0;
    c = 0;
    while (n_done1 == 0 && c < 200) begin
      @(posedge clk); #1;
      c++;
    end
    repeat (3) @(posedge clk);
    #1;
    chk("n1_done_once", 32'(n_done1), 32'd1);
    chk("n1_sb_empty",  32'(sb1.size()), 32'd0);
    chk("n1_idle",      {31'h0, busy1}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/regfile_dump_ctrl.md
REGFILE_DUMP_CTRL -- requirements
Module: regfile_dump_ctrl

Interface
REQ-001 Parameter: N_REGS, default 32, number of registers dumped, addresses 0..N_REGS-1, range 1..32.
REQ-002 Parameter: HEADER_BYTE, default 8'hA5, frame marker byte sent when the header feature is compiled in.
REQ-003 clk  in  1  single clock; all state changes on the rising edge.
REQ-004 i_reset  in  1  synchronous, active-high reset.
REQ-005 i_start  in  1  dump request from the debug unit; level-sampled.
REQ-006 i_halted  in  1  CPU halted; a start is accepted only while this input is high.
REQ-007 o_rf_addr  out  5  register-file read address (rs port).
REQ-008 i_rf_data  in  32  register-file read data; valid one rising edge after o_rf_addr changes.
REQ-009 o_tx_data  out  8  byte to the UART transmitter.
REQ-010 o_tx_valid  out  1  o_tx_data is valid.
REQ-011 i_tx_ready  in  1  transmitter accepts a byte.
REQ-012 o_busy  out  1  dump in progress.
REQ-013 o_done  out  1  one-cycle pulse when the dump completes.

Function
REQ-014 The FSM SHALL use states IDLE, ADDR, LOAD, SEND and DONE, plus HDR when REGDUMP_HEADER_EN is defined.
REQ-015 IDLE: when i_start=1 and i_halted=1, the block SHALL clear the register index, then go to HDR (if compiled) or ADDR; otherwise it stays in IDLE.
REQ-016 ADDR: the block SHALL drive o_rf_addr=index, then go to LOAD on the next edge (one-cycle read latency).
REQ-017 LOAD: the block SHALL latch i_rf_data into a 32-bit shift register, clear the byte counter, and go to SEND.
REQ-018 SEND: o_tx_valid=1 and o_tx_data=shift[31:24], so bytes go MSB first.
REQ-019 A transfer occurs only on an edge where o_tx_valid=1 and i_tx_ready=1; on that edge the shift register SHALL shift left by 8 and the byte counter SHALL increment.
REQ-020 While i_tx_ready=0, o_tx_valid and o_tx_data SHALL hold stable.
REQ-021 After the 4th transfer: if index==N_REGS-1, go to DONE; else index+1 and go to ADDR.
REQ-022 DONE: o_done SHALL be 1 for exactly one cycle, then the block returns to IDLE.
REQ-023 o_busy SHALL be 1 in every state except IDLE.
REQ-024 i_start received while busy SHALL be ignored; a held i_start re-triggers only after DONE->IDLE.
REQ-025 A deassertion of i_halted mid-dump SHALL NOT abort the dump.
REQ-026 The block SHALL send a total of 4*N_REGS bytes, plus 1 byte when the header is compiled in; there are no gaps other than transmitter backpressure and 2 cycles (ADDR, LOAD) per register.
REQ-027 o_tx_valid SHALL be combinationally 0 outside SEND/HDR.
REQ-028 o_rf_addr SHALL hold its last value outside ADDR.

Reset
REQ-029 On i_reset=1 at a rising edge: state=IDLE, index=0, o_rf_addr=0, shift=0, byte counter=0, o_tx_valid=0, o_busy=0, o_done=0.
REQ-030 Reset mid-dump SHALL abandon the frame with no further bytes sent; reset has priority over i_start.

Configuration
REQ-031 Macro REGDUMP_HEADER_EN, when defined, SHALL add state HDR (o_tx_valid=1, o_tx_data=HEADER_BYTE, go to ADDR on transfer), sent before the register 0 bytes.
REQ-032 Without REGDUMP_HEADER_EN, HDR SHALL not exist and IDLE goes directly to ADDR.

Structure
REQ-033 A shared package regdump_pkg SHALL hold the state enum/localparams, BYTES_PER_WORD=4 and the default HEADER_BYTE.
REQ-034 One sub-module, word_serializer, SHALL hold the 32-bit shift register, the 2-bit byte counter and the valid/ready handshake, with ports load, word, and a last-byte-accepted flag.

Verification
REQ-035 Regfile preloaded with reg[k]=32'h1000_0000+k, i_tx_ready=1, pulse i_start with i_halted=1 -> 128 bytes, first four 10 00 00 00, last four 10 00 00 1F; o_done pulses once.
REQ-036 Same run with REGDUMP_HEADER_EN defined -> first byte A5, then 128 bytes, 129 total.
REQ-037 i_tx_ready toggled 1-of-3 cycles -> byte stream identical to REQ-035, and o_tx_data never changes while o_tx_valid=1 and i_tx_ready=0.
REQ-038 i_start=1 with i_halted=0 -> o_busy stays 0, no bytes; a second i_start mid-dump -> only one frame sent.
REQ-039 i_reset asserted after byte 50 -> next cycle o_tx_valid=0 and o_busy=0; a new start resends from register 0.
REQ-040 N_REGS=1, reg0=32'hDEADBEEF -> bytes DE AD BE EF, then o_done.
